water_pump_ctrl: RTL and testbench
==================================

// Module: water_pump_ctrl
// PURPOSE
//  Consumer of the one-hot tank level code (0001 crit, 0010 low, 0100 mid, 1000 high, else invalid).
//  Debounces the code, then runs the tank fill pump and garden sprinkler valve via a Moore FSM.
//  Raises a latched alarm on persistent invalid codes or a stalled fill.
//  Sits between the level encoder and the pump/valve drivers of the irrigation system.
// PARAMETERS
//  STABLE_CYCLES  4     consecutive identical valid samples required to accept a new level (>=1)
//  ERR_CYCLES     8     consecutive invalid samples that force ERROR (>=1)
//  FILL_TIMEOUT   1000  max cycles in FILL without reaching high (used only with FILL_TIMEOUT_EN)
//  TO_W           16    width of the fill timeout counter; FILL_TIMEOUT < 2**TO_W
// PORTS
//  clk               in   1  system clock, rising edge
//  rst               in   1  synchronous reset, active-high
//  water_level_state in   4  one-hot level code from the level encoder
//  irrigate_req      in   1  level request to water the garden
//  clear_alarm       in   1  single-cycle pulse; acknowledges ERROR
//  pump_fill         out  1  1 = fill pump running
//  sprinkler_on      out  1  1 = sprinkler valve open
//  alarm             out  1  1 = in ERROR
//  fault_code        out  2  00 none, 01 invalid sensor code, 10 fill timeout
//  lvl_acc           out  4  currently accepted (debounced) level; 0000 = none yet
// BEHAVIOUR
//  Reset: state IDLE, lvl_acc 0000, counters 0, all outputs 0.
//  Debounce: valid code sampled every edge; stable counter clears when sample differs from previous.
//   - Code held STABLE_CYCLES consecutive edges is written to lvl_acc at that edge.
//   - STABLE_CYCLES=1: lvl_acc follows the valid input with 1 cycle latency.
//  Invalid code (0000 or >1 bit set): lvl_acc holds, stable counter clears, err counter increments.
//   - Any valid sample clears err counter; err counter saturates at ERR_CYCLES.
//   - Reaching ERR_CYCLES -> ERROR with fault_code 01 at next edge.
//  FSM (outputs decoded from registered state, Moore; output reacts 1 edge after lvl_acc changes):
//   IDLE      outputs 0. lvl_acc crit/low -> FILL; else irrigate_req & lvl_acc mid/high -> IRRIGATE.
//             lvl_acc 0000 -> stay. Fill has priority over irrigate.
//   FILL      pump_fill=1. lvl_acc high -> IDLE. irrigate_req ignored.
//   IRRIGATE  sprinkler_on=1. lvl_acc crit/low -> FILL (sprinkler closes same edge);
//             else !irrigate_req -> IDLE.
//   ERROR     pump_fill=0, sprinkler_on=0, alarm=1, fault_code held.
//             clear_alarm & err counter 0 & timeout not pending -> IDLE, fault_code 00.
//             clear_alarm while input still invalid is ignored.
//  Priority per edge: rst > invalid-error > fill-timeout > normal transitions.
//   - Reaching high in the same edge as timeout expiry: go to IDLE, no fault.
//  rst mid-FILL/IRRIGATE: outputs drop to 0 at that edge; level must be re-accepted.
//  Never pump_fill and sprinkler_on high together (assertion in bench).
// CONFIGURATION
//  FILL_TIMEOUT_EN defined:
//   - TO_W-bit counter clears on FILL entry, increments each FILL cycle.
//   - Reaching FILL_TIMEOUT in FILL -> ERROR, fault_code 10.
//  FILL_TIMEOUT_EN undefined:
//   - No counter logic; FILL lasts until high or invalid error.
//   - fault_code 10 never produced.
// STRUCTURE
//  Package water_pkg: LVL_CRIT/LOW/MID/HIGH one-hot constants, FSM state encoding,
//   FAULT_NONE/FAULT_SENSOR/FAULT_TIMEOUT codes.
//  Sub-module level_debounce:
//   - Sample, stable and err counters, lvl_acc register.
//   - Outputs lvl_acc and sensor_err pulse.
//  FSM and timeout counter stay in this module.
// TESTING
//  1 rst, hold 0001 for 4 edges -> lvl_acc=0001, pump_fill=1 next edge; hold 1000 4 edges -> pump_fill=0.
//  2 level 0100 accepted, irrigate_req=1 -> sprinkler_on=1; drop level to 0010 -> sprinkler_on=0, pump_fill=1 same edge.
//  3 glitch 0100->1000->0100 with 1000 held 3 edges (STABLE_CYCLES=4) -> lvl_acc stays 0100, no output change.
//  4 drive 0110 for 8 edges -> alarm=1, fault_code=01.
//   - clear_alarm while 0110 present -> stays ERROR.
//   - restore 0100 then clear_alarm -> IDLE, alarm=0.
//  5 FILL_TIMEOUT_EN, FILL_TIMEOUT=20, hold 0010 -> alarm=1, fault_code=10 after 20 FILL cycles.
//   - Macro off: pump_fill stays 1.
//  6 rst asserted mid-IRRIGATE -> sprinkler_on=0, lvl_acc=0000 at that edge; low level with irrigate_req -> FILL first.

Source files
------------

// File: rtl/water_pkg.sv
// water_pkg: level codes, FSM states and fault codes shared by the pump controller.
package water_pkg;
   localparam logic [3:0] LVL_CRIT = 4'b0001;
   localparam logic [3:0] LVL_LOW  = 4'b0010;
   localparam logic [3:0] LVL_MID  = 4'b0100;
   localparam logic [3:0] LVL_HIGH = 4'b1000;
   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_IRRIGATE, ST_ERROR} state_t;
   typedef enum logic [1:0] {FAULT_NONE = 2'b00, FAULT_SENSOR = 2'b01, FAULT_TIMEOUT = 2'b10} fault_t;
   function automatic logic is_valid(input logic [3:0] c);
      return $onehot(c);
   endfunction
   function automatic logic needs_fill(input logic [3:0] l);
      return l == LVL_CRIT || l == LVL_LOW;
   endfunction
   function automatic logic has_water(input logic [3:0] l);
      return l == LVL_MID || l == LVL_HIGH;
   endfunction
endpackage

// File: rtl/water_pump_ctrl_if.sv
// water_pump_ctrl_if: level input, requests and pump/valve/alarm outputs of the pump controller.
interface water_pump_ctrl_if;
   logic [3:0] water_level_state;
   logic       irrigate_req;
   logic       clear_alarm;
   logic       pump_fill;
   logic       sprinkler_on;
   logic       alarm;
   logic [1:0] fault_code;
   logic [3:0] lvl_acc;
   modport master (output water_level_state, irrigate_req, clear_alarm,
                   input pump_fill, sprinkler_on, alarm, fault_code, lvl_acc);
   modport slave (input water_level_state, irrigate_req, clear_alarm,
                  output pump_fill, sprinkler_on, alarm, fault_code, lvl_acc);
endinterface

// File: rtl/water_pump_ctrl_level_debounce.sv
// level_debounce: accepts a level code after STABLE_CYCLES identical valid samples; flags persistent invalid codes.
module level_debounce
   import water_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CYCLES    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] code,
   output logic [3:0] lvl_acc,
   output logic       sensor_err,
   output logic       err_idle
);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int EW = $clog2(ERR_CYCLES + 1);
   logic [3:0]    prev_q, prev_d, lvl_q, lvl_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [EW-1:0] err_q, err_d;
   logic          valid;
   always_comb begin
      valid      = is_valid(code);
      prev_d     = valid ? code : '0;
      stab_d     = !valid ? '0 : (code != prev_q) ? SW'(1) :
                   (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + 1'b1;
      err_d      = valid ? '0 : (err_q == EW'(ERR_CYCLES)) ? err_q : err_q + 1'b1;
      lvl_d      = (valid && stab_d == SW'(STABLE_CYCLES)) ? code : lvl_q;
      sensor_err = !valid && err_q == EW'(ERR_CYCLES - 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
         stab_q <= '0;
         err_q  <= '0;
         lvl_q  <= '0;
      end else begin
         prev_q <= prev_d;
         stab_q <= stab_d;
         err_q  <= err_d;
         lvl_q  <= lvl_d;
      end
   end
   assign lvl_acc  = lvl_q;
   assign err_idle = err_q == '0;
endmodule

// File: rtl/water_pump_ctrl.sv
// water_pump_ctrl: Moore FSM driving fill pump and sprinkler from the debounced tank level.
// Optional fill stall detection is built when FILL_TIMEOUT_EN is defined.
module water_pump_ctrl
   import water_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_CYCLES    = 8,
   parameter int FILL_TIMEOUT  = 1000,
   parameter int TO_W          = 16
) (
   input logic              clk,
   input logic              rst,
   water_pump_ctrl_if.slave bus
);
   logic [3:0] lvl;
   logic       sensor_err, err_idle, timeout;
   state_t     state_q, state_d;
   fault_t     fault_q, fault_d;
   level_debounce #(.STABLE_CYCLES(STABLE_CYCLES), .ERR_CYCLES(ERR_CYCLES)) u_deb (
      .clk        (clk),
      .rst        (rst),
      .code       (bus.water_level_state),
      .lvl_acc    (lvl),
      .sensor_err (sensor_err),
      .err_idle   (err_idle)
   );
`ifdef FILL_TIMEOUT_EN
   logic [TO_W-1:0] to_q, to_d;
   // Counter rests at zero outside FILL, so every FILL entry starts from a clean count.
   always_comb begin
      timeout = state_q == ST_FILL && to_q + 1'b1 == TO_W'(FILL_TIMEOUT);
      to_d    = state_q == ST_FILL ? to_q + 1'b1 : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) to_q <= '0;
      else to_q <= to_d;
   end
`else
   logic unused_to;
   assign unused_to = ^{TO_W[0], FILL_TIMEOUT[0]};
   assign timeout   = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     state_d = needs_fill(lvl) ? ST_FILL :
                                (bus.irrigate_req && has_water(lvl)) ? ST_IRRIGATE : ST_IDLE;
         ST_FILL:     state_d = (lvl == LVL_HIGH) ? ST_IDLE : timeout ? ST_ERROR : ST_FILL;
         ST_IRRIGATE: state_d = needs_fill(lvl) ? ST_FILL : bus.irrigate_req ? ST_IRRIGATE : ST_IDLE;
         default:     state_d = (bus.clear_alarm && err_idle) ? ST_IDLE : ST_ERROR;
      endcase
      if (state_q != ST_ERROR && sensor_err) state_d = ST_ERROR;
      fault_d = (state_q == ST_ERROR) ? ((state_d == ST_IDLE) ? FAULT_NONE : fault_q) :
                (state_d == ST_ERROR) ? (sensor_err ? FAULT_SENSOR : FAULT_TIMEOUT) : FAULT_NONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end
   assign bus.pump_fill    = state_q == ST_FILL;
   assign bus.sprinkler_on = state_q == ST_IRRIGATE;
   assign bus.alarm        = state_q == ST_ERROR;
   assign bus.fault_code   = fault_q;
   assign bus.lvl_acc      = lvl;
endmodule

// File: tb/tb_water_pump_ctrl.sv
// tb_water_pump_ctrl: directed stimulus with a behavioural model checked every cycle plus literal spot checks.
module tb_water_pump_ctrl;
   localparam int SC = 4;
   localparam int EC = 8;
   localparam int FT = 20;
`ifdef FILL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   logic go = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   water_pump_ctrl_if bus();
   water_pump_ctrl #(.STABLE_CYCLES(SC), .ERR_CYCLES(EC), .FILL_TIMEOUT(FT), .TO_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   logic [3:0] m_acc, m_last;
   int         m_run, m_err, m_tcnt, m_fault;
   bit         m_pump, m_spr, m_alarm;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   // Model: outputs follow the previous accepted level; the accepted level updates at the same edge.
   always @(posedge clk) begin : model
      logic [3:0] a0, s;
      int e0;
      bit v, hit, fill_lvl, wet_lvl;
      if (rst) begin
         m_acc = 0; m_last = 0; m_run = 0; m_err = 0; m_tcnt = 0; m_fault = 0;
         m_pump = 0; m_spr = 0; m_alarm = 0;
      end else begin
         a0 = m_acc;
         e0 = m_err;
         s = bus.water_level_state;
         v = $countones(s) == 1;
         hit = 0;
         if (v) begin
            m_run = (s == m_last) ? m_run + 1 : 1;
            m_last = s;
            m_err = 0;
            if (m_run >= SC) m_acc = s;
         end else begin
            m_run = 0;
            m_last = 0;
            if (m_err < EC) begin
               m_err++;
               hit = m_err == EC;
            end
         end
         fill_lvl = a0 == 4'd1 || a0 == 4'd2;
         wet_lvl = a0 == 4'd4 || a0 == 4'd8;
         if (m_alarm) begin
            if (bus.clear_alarm && e0 == 0) begin m_alarm = 0; m_fault = 0; end
         end else if (hit) begin
            m_alarm = 1; m_fault = 1; m_pump = 0; m_spr = 0;
         end else if (m_pump) begin
            m_tcnt++;
            if (a0 == 4'd8) m_pump = 0;
            else if (TO_EN && m_tcnt == FT) begin m_pump = 0; m_alarm = 1; m_fault = 2; end
         end else if (m_spr) begin
            if (fill_lvl) begin m_spr = 0; m_pump = 1; m_tcnt = 0; end
            else if (!bus.irrigate_req) m_spr = 0;
         end else if (fill_lvl) begin
            m_pump = 1; m_tcnt = 0;
         end else if (bus.irrigate_req && wet_lvl) m_spr = 1;
      end
   end
   always @(negedge clk) begin
      if (go) begin
         chk("model pump_fill", bus.pump_fill, m_pump);
         chk("model sprinkler_on", bus.sprinkler_on, m_spr);
         chk("model alarm", bus.alarm, m_alarm);
         chk("model fault_code", bus.fault_code, m_fault);
         chk("model lvl_acc", bus.lvl_acc, m_acc);
         chk("exclusive outputs", bus.pump_fill & bus.sprinkler_on, 0);
         assert (!(bus.pump_fill && bus.sprinkler_on)) else $error("pump and sprinkler both on");
      end
   end
   initial begin
      rst = 1;
      bus.water_level_state = 4'b0001;
      bus.irrigate_req = 0;
      bus.clear_alarm = 0;
      cyc(2);
      go = 1;
      chk("reset lvl_acc", bus.lvl_acc, 0);
      chk("reset pump", bus.pump_fill, 0);
      chk("reset alarm", bus.alarm, 0);
      rst = 0;
      cyc(4);
      chk("t1 lvl crit", bus.lvl_acc, 1);
      chk("t1 pump not yet", bus.pump_fill, 0);
      cyc(1);
      chk("t1 pump on", bus.pump_fill, 1);
      bus.water_level_state = 4'b1000;
      cyc(4);
      chk("t1 lvl high", bus.lvl_acc, 8);
      chk("t1 pump still", bus.pump_fill, 1);
      cyc(1);
      chk("t1 pump off", bus.pump_fill, 0);
      bus.water_level_state = 4'b0100;
      bus.irrigate_req = 1;
      cyc(4);
      chk("t2 lvl mid", bus.lvl_acc, 4);
      cyc(1);
      chk("t2 sprinkler on", bus.sprinkler_on, 1);
      bus.water_level_state = 4'b0010;
      cyc(4);
      chk("t2 lvl low", bus.lvl_acc, 2);
      chk("t2 sprinkler held", bus.sprinkler_on, 1);
      cyc(1);
      chk("t2 sprinkler off", bus.sprinkler_on, 0);
      chk("t2 pump on", bus.pump_fill, 1);
      bus.irrigate_req = 0;
      bus.water_level_state = 4'b1000;
      cyc(5);
      chk("t2 pump off", bus.pump_fill, 0);
      bus.water_level_state = 4'b0100;
      cyc(5);
      bus.water_level_state = 4'b1000;
      cyc(3);
      chk("t3 glitch lvl", bus.lvl_acc, 4);
      bus.water_level_state = 4'b0100;
      cyc(6);
      chk("t3 lvl kept", bus.lvl_acc, 4);
      chk("t3 pump idle", bus.pump_fill, 0);
      chk("t3 sprinkler idle", bus.sprinkler_on, 0);
      bus.water_level_state = 4'b0110;
      cyc(7);
      chk("t4 alarm not yet", bus.alarm, 0);
      cyc(1);
      chk("t4 alarm", bus.alarm, 1);
      chk("t4 fault sensor", bus.fault_code, 1);
      bus.clear_alarm = 1;
      cyc(1);
      bus.clear_alarm = 0;
      chk("t4 clear ignored", bus.alarm, 1);
      bus.water_level_state = 4'b0100;
      cyc(1);
      bus.clear_alarm = 1;
      cyc(1);
      bus.clear_alarm = 0;
      chk("t4 alarm cleared", bus.alarm, 0);
      chk("t4 fault cleared", bus.fault_code, 0);
      chk("t4 lvl held", bus.lvl_acc, 4);
      bus.water_level_state = 4'b0010;
      cyc(5);
      chk("t5 pump on", bus.pump_fill, 1);
      cyc(19);
      chk("t5 pump before limit", bus.pump_fill, 1);
      cyc(1);
`ifdef FILL_TIMEOUT_EN
      chk("t5 timeout alarm", bus.alarm, 1);
      chk("t5 timeout fault", bus.fault_code, 2);
      chk("t5 pump stopped", bus.pump_fill, 0);
      bus.clear_alarm = 1;
      cyc(1);
      bus.clear_alarm = 0;
      chk("t5 timeout cleared", bus.alarm, 0);
`else
      chk("t5 pump continues", bus.pump_fill, 1);
      chk("t5 no alarm", bus.alarm, 0);
`endif
      rst = 1;
      cyc(1);
      rst = 0;
      bus.water_level_state = 4'b0100;
      bus.irrigate_req = 1;
      cyc(5);
      chk("t6 sprinkler on", bus.sprinkler_on, 1);
      rst = 1;
      cyc(1);
      chk("t6 rst sprinkler", bus.sprinkler_on, 0);
      chk("t6 rst lvl", bus.lvl_acc, 0);
      rst = 0;
      bus.water_level_state = 4'b0010;
      cyc(4);
      chk("t6 lvl low", bus.lvl_acc, 2);
      chk("t6 pump not yet", bus.pump_fill, 0);
      cyc(1);
      chk("t6 fill first", bus.pump_fill, 1);
      chk("t6 no sprinkler", bus.sprinkler_on, 0);
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
